// File: rtl/alu_ctrl.sv
// alu_ctrl -- sequencing front end for the 64-bit ALU.
//
// Accepts register-to-register ALU requests over a valid/ready handshake,
// reads both operands from an internal register file, drives the ALU
// op/a/b for one EXEC cycle, captures the result and flags, and writes the
// result back to the destination register.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_op, req_a_idx, req_b_idx,
//   req_dst_idx                      operation and register indices
//   done                             one-cycle completion pulse (WB state)
//   zf, cf, of, sf                   flags of the last completed non-NOP op
//   wr_en, wr_idx, wr_data / wr_ack  host register write (IDLE only)
//   rd_idx / rd_data                 combinational debug read
//   alu_op, alu_a, alu_b             to ALU
//   alu_res, alu_zf/cf/of/sf         from ALU
//
// Build option: define ALU_CTRL_FASTPATH_EN to drop the READ state; operands
// are then latched at acceptance with same-cycle host writes forwarded.

package alu_pkg;
  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2
  } alu_op_t;
endpackage

module alu_ctrl #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned IW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  alu_pkg::alu_op_t      req_op,
  input  logic [IW-1:0]         req_a_idx,
  input  logic [IW-1:0]         req_b_idx,
  input  logic [IW-1:0]         req_dst_idx,
  output logic                  done,
  output logic                  zf,
  output logic                  cf,
  output logic                  of,
  output logic                  sf,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ack,
  input  logic [IW-1:0]         rd_idx,
  output logic [WIDTH-1:0]      rd_data,
  output alu_pkg::alu_op_t      alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_res,
  input  logic                  alu_zf,
  input  logic                  alu_cf,
  input  logic                  alu_of,
  input  logic                  alu_sf
);
  import alu_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  alu_op_t           op_q;
  logic [IW-1:0]     dst_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  res_q;
  logic              hzf, hcf, hof, hsf;
  // Register 0 is cleared at reset and never written, so it always reads 0.
  logic [WIDTH-1:0]  regs [NUM_REGS];

`ifdef ALU_CTRL_FASTPATH_EN
  logic [WIDTH-1:0]  a_fwd, b_fwd;

  // Operands are latched at acceptance; a host write landing in the same
  // cycle must be visible to the request, so forward it here.
  always_comb begin
    a_fwd = regs[req_a_idx];
    b_fwd = regs[req_b_idx];
    if (wr_en && wr_idx != '0 && wr_idx == req_a_idx) a_fwd = wr_data;
    if (wr_en && wr_idx != '0 && wr_idx == req_b_idx) b_fwd = wr_data;
  end
`else
  logic [IW-1:0]     a_idx_q, b_idx_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
`ifdef ALU_CTRL_FASTPATH_EN
        state_nxt = EXEC;
`else
        state_nxt = READ;
`endif
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/ALU outputs are forced quiet while reset is asserted.
  assign req_ready = (state == IDLE) && !rst;
  assign wr_ack    = wr_en && (state == IDLE) && !rst;
  assign done      = (state == WB) && !rst;
  assign alu_op    = (state == EXEC && !rst) ? op_q : ALU_NOP;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rd_data   = regs[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= ALU_NOP;
      dst_q <= '0;
`ifndef ALU_CTRL_FASTPATH_EN
      a_idx_q <= '0;
      b_idx_q <= '0;
`endif
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      hzf <= 1'b0; hcf <= 1'b0; hof <= 1'b0; hsf <= 1'b0;
      zf  <= 1'b0; cf  <= 1'b0; of  <= 1'b0; sf  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (wr_ack && wr_idx != '0) regs[wr_idx] <= wr_data;
      case (state)
        IDLE: if (req_valid) begin
          op_q  <= req_op;
          dst_q <= req_dst_idx;
`ifdef ALU_CTRL_FASTPATH_EN
          a_q <= a_fwd;
          b_q <= b_fwd;
`else
          a_idx_q <= req_a_idx;
          b_idx_q <= req_b_idx;
`endif
        end
`ifndef ALU_CTRL_FASTPATH_EN
        READ: begin
          // Read after any IDLE-cycle host write has landed.
          a_q <= regs[a_idx_q];
          b_q <= regs[b_idx_q];
        end
`endif
        EXEC: if (op_q != ALU_NOP) begin
          res_q <= alu_res;
          hzf <= alu_zf; hcf <= alu_cf; hof <= alu_of; hsf <= alu_sf;
        end
        WB: if (op_q != ALU_NOP) begin
          if (dst_q != '0) regs[dst_q] <= res_q;
          zf <= hzf; cf <= hcf; of <= hof; sf <= hsf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int W  = 64;
  localparam int N  = 16;
  localparam int IW = 4;
`ifdef ALU_CTRL_FASTPATH_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic          clk, rst;
  logic          req_valid, req_ready;
  alu_op_t       req_op;
  logic [IW-1:0] req_a_idx, req_b_idx, req_dst_idx;
  logic          done, zf, cf, of, sf;
  logic          wr_en, wr_ack;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [W-1:0]  wr_data, rd_data;
  alu_op_t       alu_op;
  logic [W-1:0]  alu_a, alu_b, alu_res;
  logic          alu_zf, alu_cf, alu_of, alu_sf;

  alu_ctrl #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a_idx(req_a_idx), .req_b_idx(req_b_idx), .req_dst_idx(req_dst_idx),
    .done(done), .zf(zf), .cf(cf), .of(of), .sf(sf),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of), .alu_sf(alu_sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: ADD = b + a, SUB = b - a, using a sign-extended sum for overflow.
  logic [W:0]   u_ext;
  logic [W:0]   s_ext;
  always_comb begin
    u_ext = '0;
    s_ext = '0;
    case (alu_op)
      ALU_ADD: begin
        u_ext = {1'b0, alu_b} + {1'b0, alu_a};
        s_ext = {alu_b[W-1], alu_b} + {alu_a[W-1], alu_a};
      end
      ALU_SUB: begin
        u_ext = {1'b0, alu_b} - {1'b0, alu_a};
        s_ext = {alu_b[W-1], alu_b} - {alu_a[W-1], alu_a};
      end
      default: ;
    endcase
    alu_res = u_ext[W-1:0];
    alu_cf  = u_ext[W];
    alu_of  = s_ext[W] != s_ext[W-1];
    alu_sf  = u_ext[W-1];
    alu_zf  = (u_ext[W-1:0] == '0);
  end

  // Reference model: register contents and architectural flags.
  logic [W-1:0] m_r [N];
  bit m_zf, m_cf, m_of, m_sf;
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] mrd(input int idx);
    return (idx == 0) ? '0 : m_r[idx];
  endfunction

  function automatic void model_exec(input alu_op_t op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input int dst);
    logic [W-1:0] r;
    bit sa, sb, sr;
    if (op == ALU_NOP) return;
    sa = a[W-1]; sb = b[W-1];
    if (op == ALU_ADD) begin
      r = b + a;
      m_cf = (r < b);
      sr = r[W-1];
      m_of = (sa == sb) && (sr != sb);
    end else begin
      r = b - a;
      m_cf = (b < a);
      sr = r[W-1];
      m_of = (sa != sb) && (sr != sb);
    end
    m_zf = (r == 0);
    m_sf = sr;
    if (dst != 0) m_r[dst] = r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_r[i] = '0;
    m_zf = 0; m_cf = 0; m_of = 0; m_sf = 0;
  endfunction

  task automatic host_write(input int idx, input logic [W-1:0] data);
    wr_en = 1; wr_idx = IW'(idx); wr_data = data;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1) begin
      n_err++; $display("FAIL host_wr_ack idx=%0d got=%b exp=1", idx, wr_ack);
    end
    @(posedge clk); #1;
    wr_en = 0;
    if (idx != 0) m_r[idx] = data;
  endtask

  task automatic run_req(input alu_op_t op, input int ai, input int bi, input int di,
                         input bit wen, input int widx, input logic [W-1:0] wdata);
    int guard;
    logic [W-1:0] ea, eb;
    alu_op_t exp_op;
    req_valid = 1; req_op = op;
    req_a_idx = IW'(ai); req_b_idx = IW'(bi); req_dst_idx = IW'(di);
    wr_en = wen; wr_idx = IW'(widx); wr_data = wdata;
    #1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL req_ready_wait got=%b exp=1", req_ready);
    end
    if (wen) begin
      n_cmp++;
      if (wr_ack !== 1'b1) begin
        n_err++; $display("FAIL accept_wr_ack got=%b exp=1", wr_ack);
      end
      if (widx != 0) m_r[widx] = wdata;
    end
    ea = mrd(ai); eb = mrd(bi);
    @(posedge clk); #1;
    req_valid = 0; wr_en = 0;
    for (int k = 1; k <= LAT; k++) begin
      exp_op = (k == LAT - 1) ? op : ALU_NOP;
      n_cmp++;
      if (done !== (k == LAT)) begin
        n_err++; $display("FAIL done_timing cyc=T+%0d got=%b exp=%b", k, done, k == LAT);
      end
      n_cmp++;
      if (alu_op !== exp_op) begin
        n_err++; $display("FAIL alu_op cyc=T+%0d got=%0d exp=%0d", k, alu_op, exp_op);
      end
      if (k == LAT - 1) begin
        n_cmp++;
        if (alu_a !== ea || alu_b !== eb) begin
          n_err++; $display("FAIL operands a=%h/%h b=%h/%h", alu_a, ea, alu_b, eb);
        end
      end
      if (k < LAT) begin @(posedge clk); #1; end
    end
    model_exec(op, ea, eb, di);
    @(posedge clk); #1;
    rd_idx = IW'(di);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL post_done ready=%b done=%b exp=1/0", req_ready, done);
    end
    n_cmp++;
    if (rd_data !== mrd(di)) begin
      n_err++; $display("FAIL wb_value R%0d got=%h exp=%h", di, rd_data, mrd(di));
    end
    n_cmp++;
    if ({zf, cf, of, sf} !== {m_zf, m_cf, m_of, m_sf}) begin
      n_err++; $display("FAIL flags zcos got=%b%b%b%b exp=%b%b%b%b",
                        zf, cf, of, sf, m_zf, m_cf, m_of, m_sf);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || done !== 1'b0 || alu_op !== ALU_NOP || wr_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs ready=%b done=%b op=%0d ack=%b exp=1/0/0/0",
                        req_ready, done, alu_op, wr_ack);
    end
    n_cmp++;
    if ({zf, cf, of, sf} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", zf, cf, of, sf);
    end
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i); #1;
      n_cmp++;
      if (rd_data !== '0) begin
        n_err++; $display("FAIL reset_reg R%0d got=%h exp=0", i, rd_data);
      end
    end
  endtask

  task automatic test_directed();
    host_write(1, 64'd5); host_write(2, 64'd7);
    run_req(ALU_ADD, 1, 2, 3, 0, 0, '0);
    rd_idx = 3; #1;
    n_cmp++;
    if (rd_data !== 64'd12 || {zf, cf, of, sf} !== 4'b0000) begin
      n_err++; $display("FAIL add_basic R3=%h flags=%b%b%b%b exp=c/0000", rd_data, zf, cf, of, sf);
    end
    host_write(2, 64'd3);
    run_req(ALU_SUB, 1, 2, 4, 0, 0, '0);
    rd_idx = 4; #1;
    n_cmp++;
    if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFE || {zf, cf, of, sf} !== 4'b0101) begin
      n_err++; $display("FAIL sub_borrow R4=%h flags=%b%b%b%b exp=fffffffffffffffe/0101",
                        rd_data, zf, cf, of, sf);
    end
    host_write(1, 64'd1); host_write(2, 64'h7FFF_FFFF_FFFF_FFFF);
    run_req(ALU_ADD, 1, 2, 5, 0, 0, '0);
    rd_idx = 5; #1;
    n_cmp++;
    if (rd_data !== 64'h8000_0000_0000_0000 || {zf, cf, of, sf} !== 4'b0011) begin
      n_err++; $display("FAIL add_overflow R5=%h flags=%b%b%b%b exp=8000000000000000/0011",
                        rd_data, zf, cf, of, sf);
    end
  endtask

  task automatic test_nop();
    run_req(ALU_SUB, 1, 1, 0, 0, 0, '0);
    rd_idx = 0; #1;
    n_cmp++;
    if (rd_data !== '0 || zf !== 1'b1) begin
      n_err++; $display("FAIL sub_to_r0 R0=%h zf=%b exp=0/1", rd_data, zf);
    end
    run_req(ALU_NOP, 1, 2, 7, 0, 0, '0);
    n_cmp++;
    if (zf !== 1'b1) begin
      n_err++; $display("FAIL nop_flags zf=%b exp=1", zf);
    end
  endtask

  task automatic test_back_to_back();
    alu_op_t qop [3] = '{ALU_ADD, ALU_SUB, ALU_ADD};
    int qa [3] = '{1, 1, 9};
    int qb [3] = '{2, 8, 9};
    int qd [3] = '{8, 9, 10};
    int idx, cyc, last;
    host_write(1, 64'd100); host_write(2, 64'd23);
    idx = 0; cyc = 0; last = 0;
    req_valid = 1; req_op = qop[0];
    req_a_idx = IW'(qa[0]); req_b_idx = IW'(qb[0]); req_dst_idx = IW'(qd[0]);
    while (idx < 3 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) begin
        if (idx > 0) begin
          n_cmp++;
          if (cyc - last != LAT + 1) begin
            n_err++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - last, LAT + 1);
          end
        end
        model_exec(qop[idx], mrd(qa[idx]), mrd(qb[idx]), qd[idx]);
        last = cyc; idx++;
        if (idx < 3) begin
          req_op = qop[idx];
          req_a_idx = IW'(qa[idx]); req_b_idx = IW'(qb[idx]); req_dst_idx = IW'(qd[idx]);
        end else req_valid = 0;
      end
    end
    req_valid = 0;
    n_cmp++;
    if (idx != 3) begin
      n_err++; $display("FAIL b2b_timeout done_count=%0d exp=3", idx);
    end
    @(posedge clk); #1;
    for (int i = 8; i <= 10; i++) begin
      rd_idx = IW'(i); #1;
      n_cmp++;
      if (rd_data !== mrd(i)) begin
        n_err++; $display("FAIL b2b_value R%0d got=%h exp=%h", i, rd_data, mrd(i));
      end
    end
  endtask

  task automatic test_busy_write();
    int guard;
    host_write(11, 64'hAAAA);
    req_valid = 1; req_op = ALU_ADD; req_a_idx = 1; req_b_idx = 2; req_dst_idx = 12;
    @(posedge clk); #1;
    req_valid = 0;
    model_exec(ALU_ADD, mrd(1), mrd(2), 12);
    wr_en = 1; wr_idx = 11; wr_data = 64'h5555;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b0) begin
      n_err++; $display("FAIL busy_wr_ack got=%b exp=0", wr_ack);
    end
    @(posedge clk); #1;
    wr_en = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL busy_done_timeout got=%b exp=1", done);
    end
    @(posedge clk); #1;
    rd_idx = 11; #1;
    n_cmp++;
    if (rd_data !== 64'hAAAA) begin
      n_err++; $display("FAIL busy_wr_ignored R11=%h exp=aaaa", rd_data);
    end
    rd_idx = 12; #1;
    n_cmp++;
    if (rd_data !== mrd(12)) begin
      n_err++; $display("FAIL busy_result R12=%h exp=%h", rd_data, mrd(12));
    end
  endtask

  task automatic test_write_and_req();
    logic [W-1:0] d;
    d = {$urandom, $urandom};
    run_req(ALU_ADD, 13, 2, 14, 1, 13, d);
    d = {$urandom, $urandom};
    run_req(ALU_SUB, 1, 13, 13, 1, 13, d);
  endtask

  task automatic test_reset_mid_exec();
    host_write(6, 64'd77);
    req_valid = 1; req_op = ALU_ADD; req_a_idx = 1; req_b_idx = 2; req_dst_idx = 6;
    @(posedge clk); #1;
    req_valid = 0;
    for (int k = 1; k < LAT - 1; k++) begin @(posedge clk); #1; end
    rst = 1; #1;
    n_cmp++;
    if (alu_op !== ALU_NOP || done !== 1'b0) begin
      n_err++; $display("FAIL rst_exec_outputs op=%0d done=%b exp=0/0", alu_op, done);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready got=%b exp=1", req_ready);
    end
    for (int k = 0; k <= LAT; k++) begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++; $display("FAIL rst_no_done cyc=%0d got=%b exp=0", k, done);
      end
      @(posedge clk); #1;
    end
    rd_idx = 6; #1;
    n_cmp++;
    if (rd_data !== '0 || {zf, cf, of, sf} !== 4'b0) begin
      n_err++; $display("FAIL rst_state R6=%h flags=%b%b%b%b exp=0/0000", rd_data, zf, cf, of, sf);
    end
  endtask

  task automatic test_random();
    alu_op_t op;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        host_write(int'($urandom_range(0, N - 1)), {$urandom, $urandom});
      op = alu_op_t'(2'($urandom_range(0, 2)));
      run_req(op, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 1)),
              int'($urandom_range(0, N - 1)), {$urandom, $urandom});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req_valid = 0; req_op = ALU_NOP;
    req_a_idx = '0; req_b_idx = '0; req_dst_idx = '0;
    wr_en = 0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    model_reset();
    test_reset();
    test_directed();
    test_nop();
    test_back_to_back();
    test_busy_write();
    test_write_and_req();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing front end for the 64-bit ALU: accepts register-to-register ALU requests over a valid/ready handshake and reads both operands from an internal register file. It drives the ALU `op`/`a`/`b` inputs for exactly one cycle, captures `res` and the four flags, and writes the result back to the destination register. It sits between the instruction decode stage and the `alu` block in `reg_file/`, acting as the initiator to which the ALU responds.

## Interface

- `WIDTH`, 64, datapath width; must equal the ALU width.
- `NUM_REGS`, 16, number of registers; power of two, at least 2; `IW = $clog2(NUM_REGS)`.

Clocking and reset (already decided): one clock, `clk`; reset is `rst`, synchronous, active-high.

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_op`  in  `alu_pkg::alu_op_t`  operation: `ALU_NOP`, `ALU_ADD` or `ALU_SUB`
- `req_a_idx`, `req_b_idx`, `req_dst_idx`  in  IW  source A, source B and destination register
- `done`  out  1  one-cycle completion pulse
- `zf`, `cf`, `of`, `sf`  out  1 each  registered flags of the last completed non-NOP op
- `wr_en`, `wr_idx`, `wr_data`  in  1/IW/WIDTH  host register write
- `wr_ack`  out  1  host write taken this cycle
- `rd_idx`  in  IW  debug read index
- `rd_data`  out  WIDTH  combinational register read
- `alu_op`  out  `alu_pkg::alu_op_t`  to ALU
- `alu_a`, `alu_b`  out  WIDTH  to ALU
- `alu_res`  in  WIDTH  from ALU
- `alu_zf`, `alu_cf`, `alu_of`, `alu_sf`  in  1 each  from ALU

## Operation

- Register 0 always reads 0. Writes to register 0, from writeback or host, are discarded.
- FSM states: IDLE, READ, EXEC, WB.
- **IDLE:** `req_ready=1`. On `req_valid`, latch op and indices, then go to READ.
- **READ:** latch `a_q = R[a_idx]` and `b_q = R[b_idx]`, then go to EXEC.
- **EXEC:**
  - Drive `alu_op = op`, `alu_a = a_q`, `alu_b = b_q`.
  - Capture `alu_res` and the four ALU flags into holding registers, then go to WB.
  - For an `ALU_NOP` request, keep `alu_op = ALU_NOP` and capture nothing.
- **WB:**
  - Non-NOP: write the held result to `R[dst_idx]` and copy the held flags to `zf/cf/of/sf`.
  - NOP: no register write; flags unchanged.
  - Pulse `done`, then go to IDLE.
- In every state other than EXEC with a non-NOP op, `alu_op = ALU_NOP`, so the ALU accumulator is left untouched. `alu_a` and `alu_b` hold `a_q` and `b_q` at all times.
- Arithmetic is defined by the ALU: ADD gives `b + a`; SUB gives `b - a`; `cf` is the carry/borrow out of bit WIDTH; `of` is signed overflow. This block does no arithmetic of its own.
- Host writes are honored only in IDLE (`wr_ack = wr_en && state==IDLE`) and are ignored otherwise. A host write and a request accepted in the same IDLE cycle: the write lands first, and the request observes the new value.
- `a_idx == b_idx`, or `dst` equal to a source, is legal. Sources are read before writeback.
- Reset at any point, including mid-EXEC:
  - FSM goes to IDLE; all registers, `a_q`, `b_q` and the flags are cleared to 0.
  - `done=0`, `wr_ack=0`, `alu_op=ALU_NOP`; `req_ready=1` from the first cycle after reset.

## Timing

- Request accepted on edge T (`req_valid && req_ready`). READ at T+1, EXEC at T+2, `done` high in cycle T+3. Register and flag updates are visible from T+4.
- Throughput: one request per 4 cycles. `req_ready` is low from T+1 until `done`, and rises in the cycle after `done`.
- `req_valid` may stay high. The next request is accepted in the cycle after `done`.
- `rd_data` is combinational and shows the written value from the cycle after WB.

## Configuration

- `ALU_CTRL_FASTPATH_EN` defined:
  - The READ state is removed and operands are latched at acceptance.
  - A same-cycle host write to a source index is forwarded into `a_q`/`b_q`.
  - Latency: `done` in cycle T+2; throughput one request per 3 cycles.
- Undefined: the 4-state behaviour above.

## Test plan

- Host-write R1=5, R2=7; ADD a=R1 b=R2 dst=R3 -> `done` at T+3; R3=12; zf=0 cf=0 of=0 sf=0; `alu_op` is ADD only in the EXEC cycle.
- R1=5, R2=3; SUB a=R1 b=R2 dst=R4 -> R4=0xFFFF_FFFF_FFFF_FFFE; cf=1 sf=1 zf=0 of=0.
- R1=1, R2=0x7FFF_FFFF_FFFF_FFFF; ADD dst=R5 -> R5=0x8000_0000_0000_0000; of=1 sf=1 cf=0.
- SUB a=R1 b=R1 dst=R0 -> `rd_data` for R0 reads 0; zf=1. A following NOP request -> `done` pulses, flags still zf=1, no register changes.
- `req_valid` held high with 3 queued requests -> `done` every 4 cycles (3 with the macro); host write during READ -> `wr_ack=0` and the register is unchanged.
- Assert `rst` in the EXEC cycle of an ADD to R6 -> R6=0, flags 0, no `done`; `req_ready=1` in the cycle after reset deasserts.
